// File: rtl/h3_xor_hash_pipe.sv
// Two-stage pipelined H3 hash: stage 1 registers per-group partial XORs of the
// selected Q rows, stage 2 folds the partials into the final index.
module h3_xor_hash_pipe #(
    parameter int KEY_WIDTH   = 32,
    parameter int INDEX_WIDTH = 12,
    parameter int GROUP       = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INDEX_WIDTH*KEY_WIDTH-1:0]   q_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [KEY_WIDTH-1:0]               key_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [KEY_WIDTH-1:0]               key_out,
    output logic [INDEX_WIDTH-1:0]             index_out,
    output logic                               idle,
    output logic [CNT_WIDTH-1:0]               hash_count
);

    localparam int NG = KEY_WIDTH / GROUP;

    logic                             ld1;
    logic                             ld2;

    logic                             s1_valid_q;
    logic                             s1_valid_d;
    logic [KEY_WIDTH-1:0]             s1_key_q;
    logic [KEY_WIDTH-1:0]             s1_key_d;
    logic [NG-1:0][INDEX_WIDTH-1:0]   s1_part_q;
    logic [NG-1:0][INDEX_WIDTH-1:0]   s1_part_d;
    logic [NG-1:0][INDEX_WIDTH-1:0]   part_comb;

    logic                             out_valid_q;
    logic                             out_valid_d;
    logic [KEY_WIDTH-1:0]             key_out_q;
    logic [KEY_WIDTH-1:0]             key_out_d;
    logic [INDEX_WIDTH-1:0]           index_out_q;
    logic [INDEX_WIDTH-1:0]           index_out_d;
    logic [INDEX_WIDTH-1:0]           index_comb;
    logic [CNT_WIDTH-1:0]             hash_count_q;
    logic [CNT_WIDTH-1:0]             hash_count_d;

    // An empty stage always loads, so bubbles collapse even under backpressure.
    always_comb begin
        ld2 = ~out_valid_q | out_ready;
        ld1 = ~s1_valid_q | ld2;
    end

    // Each group folds GROUP selected rows into one partial, straight from key_in.
    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_part
            logic [INDEX_WIDTH-1:0] grp_xor;

            always_comb begin
                grp_xor = '0;
                for (int j = 0; j < GROUP; j++) begin
                    if (key_in[gi*GROUP + j]) begin
                        grp_xor = grp_xor ^ q_in[INDEX_WIDTH*(gi*GROUP + j) +: INDEX_WIDTH];
                    end
                end
            end

            assign part_comb[gi] = grp_xor;
        end
    endgenerate

    always_comb begin
        index_comb = '0;
        for (int g = 0; g < NG; g++) begin
            index_comb = index_comb ^ s1_part_q[g];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_key_d   = s1_key_q;
        s1_part_d  = s1_part_q;
        if (ld1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_key_d  = key_in;
                s1_part_d = part_comb;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        key_out_d   = key_out_q;
        index_out_d = index_out_q;
        if (ld2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                key_out_d   = s1_key_q;
                index_out_d = index_comb;
            end
        end
    end

    // Completed-handshake counter sticks at all-ones rather than wrapping.
    always_comb begin
        hash_count_d = hash_count_q;
        if (out_valid_q && out_ready && (hash_count_q != {CNT_WIDTH{1'b1}})) begin
            hash_count_d = hash_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_key_q     <= '0;
            s1_part_q    <= '0;
            out_valid_q  <= 1'b0;
            key_out_q    <= '0;
            index_out_q  <= '0;
            hash_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_key_q     <= s1_key_d;
            s1_part_q    <= s1_part_d;
            out_valid_q  <= out_valid_d;
            key_out_q    <= key_out_d;
            index_out_q  <= index_out_d;
            hash_count_q <= hash_count_d;
        end
    end

    assign in_ready   = ld1;
    assign out_valid  = out_valid_q;
    assign key_out    = key_out_q;
    assign index_out  = index_out_q;
    assign hash_count = hash_count_q;
    assign idle       = ~s1_valid_q & ~out_valid_q;

endmodule

// File: tb/tb_h3_xor_hash_pipe.sv
// Directed and randomized checks of h3_xor_hash_pipe against a software XOR model
// driven by a fixed table of Q rows.
module tb_h3_xor_hash_pipe;

    localparam int KW = 32;
    localparam int IW = 12;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IW*KW-1:0]  q_in;
    logic              in_valid;
    logic              in_ready;
    logic [KW-1:0]     key_in;
    logic              out_valid;
    logic              out_ready;
    logic [KW-1:0]     key_out;
    logic [IW-1:0]     index_out;
    logic              idle;
    logic [CW-1:0]     hash_count;

    always #5 clk = ~clk;

    h3_xor_hash_pipe #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW), .GROUP(8), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_in     (key_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_out    (key_out),
        .index_out  (index_out),
        .idle       (idle),
        .hash_count (hash_count)
    );

    logic [IW-1:0] q_tab [KW] = '{
        12'h423, 12'hB84, 12'h5D1, 12'h19E, 12'hE07, 12'h6B2, 12'h3C9, 12'hA58,
        12'h714, 12'hC6F, 12'h28B, 12'hF30, 12'h0E5, 12'h94A, 12'hD1C, 12'h4F7,
        12'h836, 12'h2A9, 12'hB5E, 12'h67D, 12'h0C3, 12'hE98, 12'h3F4, 12'h71B,
        12'hA0F, 12'h5C2, 12'h8E6, 12'h139, 12'hCD5, 12'h47A, 12'hF81, 12'h26C
    };

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] hash_model(input logic [KW-1:0] k);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < KW; i++) begin
            if (k[i]) r = r ^ q_tab[i];
        end
        return r;
    endfunction

    // Scoreboard: keys accepted but not yet emitted, in order.
    logic [KW-1:0] exp_q [$];
    int            hs_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                hs_count = 0;
            end else begin
                if (out_valid && out_ready) begin
                    logic [KW-1:0] ek;
                    hs_count++;
                    check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        ek = exp_q.pop_front();
                        check_eq("sb_key", 64'(key_out), 64'(ek));
                        check_eq("sb_index", 64'(index_out), 64'(hash_model(ek)));
                    end
                    for (int i = 0; i < KW; i++) begin
                        if (key_out == (32'h1 << i)) check_eq("single_bit_row", 64'(index_out), 64'(q_tab[i]));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(key_in);
            end
        end
    end

    task automatic send_and_wait(input logic [KW-1:0] k, input logic [IW-1:0] exp_idx, input string tag);
        int lat;
        in_valid  = 1'b1;
        key_in    = k;
        out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd2);
        check_eq({tag, "_index"}, 64'(index_out), 64'(exp_idx));
        check_eq({tag, "_key"}, 64'(key_out), 64'(k));
        $display("directed %s key=0x%08h index=0x%03h latency=%0d", tag, k, index_out, lat);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [KW-1:0] bp_key [4] = '{32'h4, 32'h8, 32'h10, 32'h20};
    logic [KW-1:0] rnd_keys [1000];

    initial begin
        int ov_cycles, rises, accepts, guard, idx, budget;
        logic prev, acc;

        for (int i = 0; i < KW; i++) q_in[IW*i +: IW] = q_tab[i];

        // Reset held with in_valid asserted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        key_in    = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        check_eq("rst_hash_count", 64'(hash_count), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_key_out", 64'(key_out), 64'd0);
        check_eq("rst_index_out", 64'(index_out), 64'd0);

        send_and_wait(32'h1, 12'h423, "key1");
        send_and_wait(32'h2, 12'hB84, "key2");
        send_and_wait(32'h3, 12'hFA7, "key3");
        send_and_wait(32'h0, 12'h000, "key0");
        check_eq("basic_hash_count", 64'(hash_count), 64'd4);

        // Streaming: 64 back-to-back keys, consumer always ready.
        pulse_reset();
        ov_cycles = 0;
        rises     = 0;
        prev      = 1'b0;
        for (int c = 0; c < 70; c++) begin
            in_valid = (c < 64);
            key_in   = $urandom;
            @(posedge clk); #1;
            if (out_valid) ov_cycles++;
            if (out_valid && !prev) rises++;
            prev = out_valid;
        end
        check_eq("stream_out_cycles", 64'(ov_cycles), 64'd64);
        check_eq("stream_contiguous", 64'(rises), 64'd1);
        check_eq("stream_hash_count", 64'(hash_count), 64'd64);
        check_eq("stream_idle", 64'(idle), 64'd1);
        $display("stream 64 keys: out_cycles=%0d hash_count=%0d", ov_cycles, hash_count);

        // Backpressure: consumer stalls for 5 cycles.
        out_ready = 1'b0;
        accepts   = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            key_in   = bp_key[accepts];
            check_eq("bp_in_ready", 64'(in_ready), 64'(c < 2));
            if (in_ready) accepts++;
            @(posedge clk); #1;
            if (out_valid) begin
                check_eq("bp_hold_key", 64'(key_out), 64'(bp_key[0]));
                check_eq("bp_hold_index", 64'(index_out), 64'(q_tab[2]));
            end
        end
        check_eq("bp_accepts_stalled", 64'(accepts), 64'd2);
        out_ready = 1'b1;
        guard     = 0;
        while (accepts < 4 && guard < 20) begin
            in_valid = 1'b1;
            key_in   = bp_key[accepts];
            if (in_ready) accepts++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_accepts_total", 64'(accepts), 64'd4);
        check_eq("bp_drained", 64'(exp_q.size()), 64'd0);
        check_eq("bp_idle", 64'(idle), 64'd1);

        // Random valid/ready toggling over 1000 keys.
        rnd_keys[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) rnd_keys[i+1] = 32'h1 << i;
        for (int i = 33; i < 1000; i++) rnd_keys[i] = $urandom;
        idx      = 0;
        budget   = 0;
        in_valid = 1'b1;
        while (idx < 1000 && budget < 20000) begin
            key_in    = rnd_keys[idx];
            out_ready = ($urandom_range(0, 3) != 0);
            acc       = in_valid && in_ready;
            @(posedge clk); #1;
            budget++;
            if (acc) begin
                idx++;
                in_valid = (idx < 1000) && ($urandom_range(0, 3) != 0);
            end else if (!in_valid) begin
                in_valid = (idx < 1000) && ($urandom_range(0, 3) != 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rand_all_accepted", 64'(idx), 64'd1000);
        check_eq("rand_drained", 64'(exp_q.size()), 64'd0);
        check_eq("rand_hash_count", 64'(hash_count), 64'(hs_count));
        check_eq("rand_idle", 64'(idle), 64'd1);
        $display("random 1000 keys: cycles=%0d hash_count=%0d", budget, hash_count);

        // Reset with two keys in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        key_in    = 32'h5;
        @(posedge clk); #1;
        key_in = 32'h6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("mid_inflight", 64'(out_valid), 64'd1);
        pulse_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_eq("mid_no_output", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        check_eq("mid_hash_count", 64'(hash_count), 64'd0);
        check_eq("mid_idle", 64'(idle), 64'd1);
        send_and_wait(32'h3, 12'hFA7, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
